// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_resolve_unit                                          |
// | Description : Registered ID/EX branch resolution. Computes the branch      |
// |               target, evaluates the branch condition, drives a multi-cycle |
// |               IF/ID flush and keeps saturating branch statistics.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module branch_resolve_unit #(
  parameter int DATA_W       = 32,
  parameter int IMM_W        = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic              stall_i,
  input  logic [2:0]        cond_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] rs_val_i,
  input  logic [DATA_W-1:0] rt_val_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic              out_valid_o,
  output logic              taken_o,
  output logic [DATA_W-1:0] target_o,
  output logic              flush_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  taken_cnt_o
);

  // Flush counter must be able to hold FLUSH_CYCLES itself.
  localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_BEQ  = 3'b001;
  localparam logic [2:0] C_BNE  = 3'b010;
  localparam logic [2:0] C_BLEZ = 3'b011;
  localparam logic [2:0] C_BGTZ = 3'b100;
  localparam logic [2:0] C_BLTZ = 3'b101;
  localparam logic [2:0] C_BGEZ = 3'b110;
  localparam logic [2:0] C_RSVD = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [FCW-1:0]     fcnt_q, fcnt_d;
  logic               out_valid_q, out_valid_d;
  logic               taken_q, taken_d;
  logic [DATA_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;

  logic [DATA_W-1:0]  imm_sext_w;
  logic [DATA_W-1:0]  target_w;
  logic               rs_neg_w;
  logic               rs_zero_w;
  logic               cmp_w;
  logic               cond_ok_w;
  logic               accept_w;

  // Target arithmetic: offset is in words, so shift the sign-extended immediate by two.
  assign imm_sext_w = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign target_w   = pc_plus4_i + {imm_sext_w[DATA_W-3:0], 2'b00};

  // Signed tests against zero only need the sign bit and a zero detect.
  assign rs_neg_w  = rs_val_i[DATA_W-1];
  assign rs_zero_w = (rs_val_i == '0);

  assign cond_ok_w = (cond_i != C_NONE) && (cond_i != C_RSVD);
  // Instructions arriving while flush is high are on the wrong path and are dropped.
  assign accept_w  = in_valid_i && !stall_i && (state_q == S_IDLE) && cond_ok_w;

  // Branch condition evaluation; rt only matters for the equality forms.
  always_comb begin
    cmp_w = 1'b0;
    case (cond_i)
      C_BEQ:   cmp_w = (rs_val_i == rt_val_i);
      C_BNE:   cmp_w = (rs_val_i != rt_val_i);
      C_BLEZ:  cmp_w = rs_neg_w | rs_zero_w;
      C_BGTZ:  cmp_w = !rs_neg_w && !rs_zero_w;
      C_BLTZ:  cmp_w = rs_neg_w;
      C_BGEZ:  cmp_w = !rs_neg_w;
      default: cmp_w = 1'b0;
    endcase
  end

  // Next-state for outputs, statistics and the flush FSM; a stall freezes everything.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    out_valid_d  = out_valid_q;
    taken_d      = taken_q;
    target_d     = target_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;

    if (!stall_i) begin
      out_valid_d = accept_w;
      taken_d     = accept_w && cmp_w;

      if (accept_w) begin
        target_d = target_w;
        if (branch_cnt_q != '1) begin
          branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (cmp_w && (taken_cnt_q != '1)) begin
          taken_cnt_d = taken_cnt_q + 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (accept_w && cmp_w) begin
            state_d = S_FLUSH;
            fcnt_d  = FCW'(FLUSH_CYCLES);
          end
        end
        S_FLUSH: begin
          if (fcnt_q == FCW'(1)) begin
            state_d = S_IDLE;
            fcnt_d  = '0;
          end else begin
            fcnt_d  = fcnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fcnt_q       <= '0;
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      out_valid_q  <= out_valid_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign taken_o      = taken_q;
  assign target_o     = target_q;
  assign flush_o      = (state_q == S_FLUSH);
  assign branch_cnt_o = branch_cnt_q;
  assign taken_cnt_o  = taken_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_branch_resolve_unit                                       |
// | Description : Self-checking bench for branch_resolve_unit. Two instances   |
// |               (1-cycle flush / 16-bit counters, 2-cycle flush / 3-bit      |
// |               counters) share stimulus and are compared to a model.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        stall;
  logic [2:0]  cond;
  logic [31:0] pc_plus4;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [15:0] imm;

  logic        ov_a, tk_a, fl_a;
  logic [31:0] tg_a;
  logic [15:0] bc_a, tc_a;
  logic        ov_b, tk_b, fl_b;
  logic [31:0] tg_b;
  logic [2:0]  bc_b, tc_b;

  int npass = 0;
  int ntot  = 0;

  // Model state, index 0 = instance A, index 1 = instance B.
  int          FC[2]   = '{1, 2};
  int          CMAX[2] = '{65535, 7};
  int          m_fl[2];
  int          m_bc[2];
  int          m_tc[2];
  bit          m_ov[2];
  bit          m_tk[2];
  logic [31:0] m_tg[2];

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_W(32), .IMM_W(16), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .stall_i(stall), .cond_i(cond),
    .pc_plus4_i(pc_plus4), .rs_val_i(rs_val), .rt_val_i(rt_val), .imm_i(imm),
    .out_valid_o(ov_a), .taken_o(tk_a), .target_o(tg_a), .flush_o(fl_a),
    .branch_cnt_o(bc_a), .taken_cnt_o(tc_a)
  );

  branch_resolve_unit #(.DATA_W(32), .IMM_W(16), .FLUSH_CYCLES(2), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .stall_i(stall), .cond_i(cond),
    .pc_plus4_i(pc_plus4), .rs_val_i(rs_val), .rt_val_i(rt_val), .imm_i(imm),
    .out_valid_o(ov_b), .taken_o(tk_b), .target_o(tg_b), .flush_o(fl_b),
    .branch_cnt_o(bc_b), .taken_cnt_o(tc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic bit ref_taken(input logic [2:0] c, input logic [31:0] rs, input logic [31:0] rt);
    int srs;
    srs = $signed(rs);
    case (c)
      3'd1:    return rs == rt;
      3'd2:    return rs != rt;
      3'd3:    return srs <= 0;
      3'd4:    return srs > 0;
      3'd5:    return srs < 0;
      3'd6:    return srs >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] im);
    longint t;
    t = longint'(pc) + longint'($signed(im)) * 4;
    return t[31:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_fl[k] = 0; m_bc[k] = 0; m_tc[k] = 0;
      m_ov[k] = 1'b0; m_tk[k] = 1'b0; m_tg[k] = '0;
    end
  endtask

  // One clock edge of behaviour, using the inputs that were present at the edge.
  task automatic model_step();
    bit busy, acc, t;
    if (stall) return;
    for (int k = 0; k < 2; k++) begin
      busy = (m_fl[k] > 0);
      if (busy) m_fl[k]--;
      acc = in_valid && !busy && (cond != 3'd0) && (cond != 3'd7);
      if (acc) begin
        t = ref_taken(cond, rs_val, rt_val);
        m_ov[k] = 1'b1;
        m_tk[k] = t;
        m_tg[k] = ref_target(pc_plus4, imm);
        if (m_bc[k] < CMAX[k]) m_bc[k]++;
        if (t && m_tc[k] < CMAX[k]) m_tc[k]++;
        if (t) m_fl[k] = FC[k];
      end else begin
        m_ov[k] = 1'b0;
        m_tk[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("A.out_valid", {31'b0, ov_a}, {31'b0, m_ov[0]});
    chk("A.taken",     {31'b0, tk_a}, {31'b0, m_tk[0]});
    chk("A.target",    tg_a, m_tg[0]);
    chk("A.flush",     {31'b0, fl_a}, {31'b0, (m_fl[0] > 0)});
    chk("A.branch_cnt", {16'b0, bc_a}, 32'(m_bc[0]));
    chk("A.taken_cnt",  {16'b0, tc_a}, 32'(m_tc[0]));
    chk("B.out_valid", {31'b0, ov_b}, {31'b0, m_ov[1]});
    chk("B.taken",     {31'b0, tk_b}, {31'b0, m_tk[1]});
    chk("B.target",    tg_b, m_tg[1]);
    chk("B.flush",     {31'b0, fl_b}, {31'b0, (m_fl[1] > 0)});
    chk("B.branch_cnt", {29'b0, bc_b}, 32'(m_bc[1]));
    chk("B.taken_cnt",  {29'b0, tc_b}, 32'(m_tc[1]));
  endtask

  // Drive inputs, take one edge, update the model, then sample 1 time unit later.
  task automatic step(input bit v, input bit s, input logic [2:0] c, input logic [31:0] pc,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im);
    in_valid = v; stall = s; cond = c; pc_plus4 = pc; rs_val = rs; rt_val = rt; imm = im;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 16'h0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".A.out_valid"}, {31'b0, ov_a}, 32'h0);
    chk({tag, ".A.taken"},     {31'b0, tk_a}, 32'h0);
    chk({tag, ".A.target"},    tg_a, 32'h0);
    chk({tag, ".A.flush"},     {31'b0, fl_a}, 32'h0);
    chk({tag, ".A.branch_cnt"}, {16'b0, bc_a}, 32'h0);
    chk({tag, ".A.taken_cnt"},  {16'b0, tc_a}, 32'h0);
    chk({tag, ".B.flush"},     {31'b0, fl_b}, 32'h0);
    chk({tag, ".B.out_valid"}, {31'b0, ov_b}, 32'h0);
    chk({tag, ".B.branch_cnt"}, {29'b0, bc_b}, 32'h0);
    chk({tag, ".B.taken_cnt"},  {29'b0, tc_b}, 32'h0);
  endtask

  initial begin
    logic [31:0] rs_r, rt_r;

    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; cond = 3'd0;
    pc_plus4 = '0; rs_val = '0; rt_val = '0; imm = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // BEQ taken, forward target
    step(1'b1, 1'b0, 3'd1, 32'h104, 32'h5, 32'h5, 16'h0003);
    chk("beq.target", tg_a, 32'h110);
    chk("beq.taken",  {31'b0, tk_a}, 32'h1);
    chk("beq.flush",  {31'b0, fl_a}, 32'h1);
    bubble(1);
    chk("beq.flush_one_cycle", {31'b0, fl_a}, 32'h0);
    bubble(2);

    // BLTZ not taken with backward target, then BLTZ taken on a negative operand
    step(1'b1, 1'b0, 3'd5, 32'h104, 32'h0, 32'h0, 16'hFFFE);
    chk("bltz0.target", tg_a, 32'hFC);
    chk("bltz0.taken",  {31'b0, tk_a}, 32'h0);
    step(1'b1, 1'b0, 3'd5, 32'h104, 32'h80000000, 32'h0, 16'hFFFE);
    chk("bltzneg.taken", {31'b0, tk_a}, 32'h1);
    bubble(3);

    // Target wrap-around
    step(1'b1, 1'b0, 3'd1, 32'h4, 32'h7, 32'h7, 16'hFFFE);
    chk("wrap.target", tg_a, 32'hFFFFFFFC);
    bubble(3);

    // Back-to-back BEQs: the ones arriving during flush are squashed
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'd1, 32'h200 + 32'(i*4), 32'h9, 32'h9, 16'h0010);
    bubble(3);

    // Stall held during flush: flush and outputs frozen
    step(1'b1, 1'b0, 3'd1, 32'h300, 32'h1, 32'h1, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 3'd2, 32'h400, 32'h1, 32'h2, 16'h0008);
      chk("stall.flush_held", {31'b0, fl_a}, 32'h1);
      chk("stall.target_held", tg_a, 32'h310);
    end
    bubble(3);

    // Counter saturation on the 3-bit instance
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 3'd4, 32'h1000, 32'h1, 32'h0, 16'h0001);
      bubble(2);
    end
    chk("sat.B.branch_cnt", {29'b0, bc_b}, 32'h7);
    chk("sat.B.taken_cnt",  {29'b0, tc_b}, 32'h7);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       rs_r = 32'h0;
        1:       rs_r = 32'h80000000;
        default: rs_r = $urandom;
      endcase
      rt_r = ($urandom_range(0, 1) == 1) ? rs_r : $urandom;
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 15), 3'($urandom_range(0, 7)),
           {$urandom, 2'b00} >> 0, rs_r, rt_r, 16'($urandom));
    end
    bubble(3);

    // Asynchronous reset in the middle of a flush
    step(1'b1, 1'b0, 3'd1, 32'h500, 32'h3, 32'h3, 16'h0002);
    chk("midflush.flush_before", {31'b0, fl_b}, 32'h1);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    #2;
    rst = 1'b0;
    step(1'b1, 1'b0, 3'd6, 32'h600, 32'h1, 32'h0, 16'h0001);
    chk("post_rst.accept", {31'b0, ov_a}, 32'h1);
    chk("post_rst.branch_cnt", {16'b0, bc_a}, 32'h1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
